ro_measure_sequencer: RTL and testbench
=======================================

# ro_measure_sequencer

Autonomous measurement sequencer for the temperature-sensing ring-oscillator array. It replaces manual host toggling of the counter control inputs. On a start request it clears the frequency counters, opens a gate window of a programmed number of `clk` cycles, latches the counts and serialises each enabled channel in turn through the Manchester readout shift register. It sits between the host-facing inputs and the per-oscillator measurement units plus readout logic.

## Interface
- `NUM_CHANNELS`, 3: number of oscillator counters; at most 4.
- `COUNTER_LENGTH`, 20: counter width; a frame is `COUNTER_LENGTH+4` bits.
- `GATE_WIDTH`, 16: width of the gate-length register.
- `HOLD_CYCLES`, 4: width in `clk` cycles of `ctr_reset`/`latch_counter` pulses, and of the post-latch settle; at least 1. Covers synchronisation into the oscillator domains.
- `SEND_LATENCY`, 3: synchroniser depth of the readout `send_counter` path.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high; forces IDLE and all outputs to 0.
- `start`, in, 1: sampled only in IDLE.
- `continuous`, in, 1: sampled at end of sweep; 1 means start a new sweep.
- `gate_cycles`, in, `GATE_WIDTH`: gate window length; captured on accepted start.
- `channel_mask`, in, `NUM_CHANNELS`: enabled channels; captured on accepted start.
- `ctr_reset`, out, 1: to all measurement units.
- `latch_counter`, out, 1: to all measurement units.
- `send_counter`, out, 1: to the readout loader.
- `counter_select`, out, 2: readout channel select.
- `frame_active`, out, 1: high while a frame is being loaded/shifted.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse per completed sweep.

## Operation
- States: IDLE, CLEAR, GATE, LATCH, SETTLE, LOAD, SHIFT, DONE. A single down-counter times each state.
- IDLE: if `start`=1 and `channel_mask`≠0, capture mask and gate and go to CLEAR. A zero mask leaves the block in IDLE with no outputs driven.
- CLEAR: `ctr_reset`=1 for `HOLD_CYCLES` cycles.
- GATE: all controls low for `gate_cycles` cycles. A value of 0 is treated as 1.
- LATCH: `latch_counter`=1 for `HOLD_CYCLES` cycles.
- SETTLE: all controls low for `HOLD_CYCLES` cycles.
- Channel selection picks the lowest enabled index not yet sent. It does not wrap.
- LOAD: one cycle with `send_counter`=1 and `counter_select`=channel.
- SHIFT: lasts `SEND_LATENCY+COUNTER_LENGTH+4` cycles. `counter_select` is held at the channel value.
- After SHIFT, go to LOAD for the next enabled channel, or to DONE if none remain.
- DONE: one cycle, `done`=1.
  - If `continuous`=1, go to CLEAR with the captured mask and gate.
  - Otherwise go to IDLE.
- `start` is ignored while not in IDLE. Mask and gate inputs may change mid-sweep without effect.
- `counter_select` is 0 outside LOAD/SHIFT.

## Timing
- Every output resets to 0. All outputs are registered and glitch-free, since they feed asynchronous domains.
- Accepted start at cycle t:
  - CLEAR runs t+1 … t+HOLD_CYCLES.
  - GATE starts at t+HOLD_CYCLES+1.
- Sweep length, from CLEAR entry to DONE exclusive: `3·HOLD_CYCLES + G + N·(1+SEND_LATENCY+COUNTER_LENGTH+4)`. G is the effective gate length; N is the popcount of the mask.
- `busy`=1 from CLEAR entry through the last SHIFT cycle, and 0 in DONE and IDLE. In continuous mode `busy` drops only for the DONE cycle.
- `frame_active`=1 in LOAD and SHIFT.
- Reset asserted mid-sweep: all outputs go to 0 immediately, and any partial frame is abandoned.

## Structure
- Package `ro_seq_pkg` holds:
  - the state enum;
  - the frame-length constant `FRAME_BITS = COUNTER_LENGTH+4`;
  - the preamble value 4'b1010, shared with the readout.
- One sub-module, `seq_timer`: a loadable down-counter with a `zero` flag, sized to max(`GATE_WIDTH`, log2 frame length).
- Lowest-set-bit channel pick is a function in the package.

## Test plan
- Defaults; mask=3'b111, gate=100, start at t → CLEAR t+1…t+4, GATE 100 cycles, `send_counter` pulses at t+113, t+141, t+169; `done` at t+197.
- mask=3'b010, gate=0 → gate lasts 1 cycle; a single frame with `counter_select`=1; `done` 1+4+1+4+4+28 = 42 cycles after start.
- mask=0, `start` held high → block stays in IDLE; all outputs 0 indefinitely.
- `continuous`=1, mask=3'b101 → `done` every sweep; select sequence 0,2,0,2…; `busy` low only on DONE cycles.
- Reset asserted during the second SHIFT → all outputs 0 the same cycle; a new `start` after release runs a full sweep from CLEAR.
- `start` and mask changed mid-GATE → no effect; the captured mask is still used.

Source files
------------

// File: rtl/ro_seq_pkg.sv
// rtl/ro_seq_pkg.sv - shared types, frame constants and channel pick for the RO measurement sequencer
package ro_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_GATE   = 3'd2,
        S_LATCH  = 3'd3,
        S_SETTLE = 3'd4,
        S_LOAD   = 3'd5,
        S_SHIFT  = 3'd6,
        S_DONE   = 3'd7
    } seq_state_t;

    localparam logic [3:0] PREAMBLE               = 4'b1010;
    localparam int         PREAMBLE_BITS          = $bits(PREAMBLE);
    localparam int         DEFAULT_COUNTER_LENGTH = 20;
    localparam int         FRAME_BITS             = DEFAULT_COUNTER_LENGTH + PREAMBLE_BITS;
    localparam int         MAX_CHANNELS           = 4;

    // Lowest set index wins; an empty mask yields 0, which callers never rely on.
    function automatic logic [1:0] lowest_set(input logic [MAX_CHANNELS-1:0] mask);
        logic [1:0] pick;
        pick = 2'd0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                pick = 2'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable down-counter with a zero flag, times every sequencer state
module seq_timer #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/ro_measure_sequencer.sv
// rtl/ro_measure_sequencer.sv - clear/gate/latch/readout sweep over the ring-oscillator counters
module ro_measure_sequencer
    import ro_seq_pkg::*;
#(
    parameter int NUM_CHANNELS   = 3,
    parameter int COUNTER_LENGTH = DEFAULT_COUNTER_LENGTH,
    parameter int GATE_WIDTH     = 16,
    parameter int HOLD_CYCLES    = 4,
    parameter int SEND_LATENCY   = 3
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_continuous,
    input  logic [GATE_WIDTH-1:0]   i_gate_cycles,
    input  logic [NUM_CHANNELS-1:0] i_channel_mask,
    output logic                    o_ctr_reset,
    output logic                    o_latch_counter,
    output logic                    o_send_counter,
    output logic [1:0]              o_counter_select,
    output logic                    o_frame_active,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int FRAME_LEN    = COUNTER_LENGTH + PREAMBLE_BITS;
    localparam int SHIFT_CYCLES = SEND_LATENCY + FRAME_LEN;
    localparam int TW_SHIFT     = $clog2(SHIFT_CYCLES + 1);
    localparam int TW_HOLD      = $clog2(HOLD_CYCLES + 1);
    localparam int TW_A         = (GATE_WIDTH > TW_SHIFT) ? GATE_WIDTH : TW_SHIFT;
    localparam int TIMER_W      = (TW_A > TW_HOLD) ? TW_A : TW_HOLD;

    seq_state_t                r_state;
    seq_state_t                w_next_state;
    logic [NUM_CHANNELS-1:0]   r_mask;
    logic [GATE_WIDTH-1:0]     r_gate;
    logic [NUM_CHANNELS-1:0]   r_pending;
    logic [1:0]                r_channel;
    logic [MAX_CHANNELS-1:0]   w_pending4;
    logic [NUM_CHANNELS-1:0]   w_chan_bit;
    logic [1:0]                w_pick;
    logic                      w_timer_load;
    logic [TIMER_W-1:0]        w_timer_value;
    logic                      w_timer_zero;

    logic                      w_ctr_reset;
    logic                      w_latch_counter;
    logic                      w_send_counter;
    logic [1:0]                w_counter_select;
    logic                      w_frame_active;
    logic                      w_busy;
    logic                      w_done;

    always_comb begin
        w_pending4 = '0;
        w_pending4[NUM_CHANNELS-1:0] = r_pending;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_chan_bit[i] = (r_channel == 2'(i));
        end
    end

    assign w_pick = lowest_set(w_pending4);

    seq_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_load  (w_timer_load),
        .i_value (w_timer_value),
        .o_zero  (w_timer_zero)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_start && (i_channel_mask != '0)) w_next_state = S_CLEAR;
            S_CLEAR:  if (w_timer_zero) w_next_state = S_GATE;
            S_GATE:   if (w_timer_zero) w_next_state = S_LATCH;
            S_LATCH:  if (w_timer_zero) w_next_state = S_SETTLE;
            S_SETTLE: if (w_timer_zero) w_next_state = S_LOAD;
            S_LOAD:   w_next_state = S_SHIFT;
            S_SHIFT:  if (w_timer_zero) w_next_state = (r_pending != '0) ? S_LOAD : S_DONE;
            S_DONE:   w_next_state = i_continuous ? S_CLEAR : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Every state change reloads the timer with the length of the state being entered, minus one.
    always_comb begin
        w_timer_load  = (w_next_state != r_state);
        w_timer_value = '0;
        case (w_next_state)
            S_CLEAR, S_LATCH, S_SETTLE: w_timer_value = TIMER_W'(HOLD_CYCLES - 1);
            S_GATE:  w_timer_value = (r_gate == '0) ? '0 : TIMER_W'(r_gate) - TIMER_W'(1);
            S_SHIFT: w_timer_value = TIMER_W'(SHIFT_CYCLES - 1);
            default: w_timer_value = '0;
        endcase
    end

    always_comb begin
        w_ctr_reset      = (w_next_state == S_CLEAR);
        w_latch_counter  = (w_next_state == S_LATCH);
        w_send_counter   = (w_next_state == S_LOAD);
        w_frame_active   = (w_next_state == S_LOAD) || (w_next_state == S_SHIFT);
        w_busy           = (w_next_state != S_IDLE) && (w_next_state != S_DONE);
        w_done           = (w_next_state == S_DONE);
        w_counter_select = 2'd0;
        if (w_next_state == S_LOAD) begin
            w_counter_select = w_pick;
        end else if (w_next_state == S_SHIFT) begin
            w_counter_select = r_channel;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mask    <= '0;
            r_gate    <= '0;
            r_pending <= '0;
            r_channel <= 2'd0;
        end else begin
            if ((r_state == S_IDLE) && (w_next_state == S_CLEAR)) begin
                r_mask <= i_channel_mask;
                r_gate <= i_gate_cycles;
            end
            if (w_next_state == S_CLEAR) begin
                r_pending <= (r_state == S_IDLE) ? i_channel_mask : r_mask;
            end else if (r_state == S_LOAD) begin
                r_pending <= r_pending & ~w_chan_bit;
            end
            if (w_next_state == S_LOAD) begin
                r_channel <= w_pick;
            end
        end
    end

    // Outputs cross into oscillator domains, so they come straight from flops.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ctr_reset      <= 1'b0;
            o_latch_counter  <= 1'b0;
            o_send_counter   <= 1'b0;
            o_counter_select <= 2'd0;
            o_frame_active   <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            o_ctr_reset      <= w_ctr_reset;
            o_latch_counter  <= w_latch_counter;
            o_send_counter   <= w_send_counter;
            o_counter_select <= w_counter_select;
            o_frame_active   <= w_frame_active;
            o_busy           <= w_busy;
            o_done           <= w_done;
        end
    end

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// tb/tb_ro_measure_sequencer.sv - table vectors plus event scoreboard for ro_measure_sequencer
module tb_ro_measure_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cont;
    logic [15:0] gate;
    logic [2:0]  mask;
    logic        o_ctr_reset, o_latch_counter, o_send_counter, o_frame_active, o_busy, o_done;
    logic [1:0]  o_counter_select;

    always #5 clk = ~clk;

    ro_measure_sequencer dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_start          (start),
        .i_continuous     (cont),
        .i_gate_cycles    (gate),
        .i_channel_mask   (mask),
        .o_ctr_reset      (o_ctr_reset),
        .o_latch_counter  (o_latch_counter),
        .o_send_counter   (o_send_counter),
        .o_counter_select (o_counter_select),
        .o_frame_active   (o_frame_active),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    typedef struct {
        bit is_done;
        int at;
        int sel;
    } ev_t;

    typedef struct {
        logic [2:0] mask;
        int         gate;
        int         done_off;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[7];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_done = -1;
    int   win_lo = -1;
    int   win_hi = -2;
    int   busy_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst) begin
            if (o_send_counter || o_done) begin
                if (o_done) last_done = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", int'(o_done), int'(e.is_done));
                    check("event_cycle", cyc, e.at);
                    if (!e.is_done) begin
                        check("send_select", int'(o_counter_select), e.sel);
                        check("send_frame_active", int'(o_frame_active), 1);
                    end else begin
                        check("done_busy", int'(o_busy), 0);
                    end
                end
            end
            if (!o_frame_active && o_counter_select != 2'd0)
                check("select_outside_frame", int'(o_counter_select), 0);
            if (cyc >= win_lo && cyc <= win_hi && !o_busy) busy_low++;
        end
    end

    // Model: first LOAD at T+1+3*HOLD+G, frames every 1+3+24 cycles, DONE right after the last SHIFT.
    task automatic push_sweep(input logic [2:0] m, input int g, input int t);
        int geff;
        int at;
        geff = (g == 0) ? 1 : g;
        at   = t + 1 + 12 + geff;
        for (int ch = 0; ch < 3; ch++) begin
            if (m[ch]) begin
                sb.push_back('{is_done: 1'b0, at: at, sel: ch});
                at += 28;
            end
        end
        sb.push_back('{is_done: 1'b1, at: at, sel: 0});
    endtask

    task automatic start_sweep(input logic [2:0] m, input int g, output int t);
        @(negedge clk);
        mask  = m;
        gate  = 16'(g);
        start = 1'b1;
        t     = cyc;
        push_sweep(m, g, t);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    function automatic int all_outs();
        return int'({o_ctr_reset, o_latch_counter, o_send_counter, o_counter_select,
                     o_frame_active, o_busy, o_done});
    endfunction

    initial begin
        int t;
        int any;
        vecs[0] = '{mask: 3'b111, gate: 100, done_off: 197};
        vecs[1] = '{mask: 3'b010, gate: 0,   done_off: 42};
        vecs[2] = '{mask: 3'b001, gate: 1,   done_off: 42};
        vecs[3] = '{mask: 3'b100, gate: 5,   done_off: 46};
        vecs[4] = '{mask: 3'b011, gate: 2,   done_off: 71};
        vecs[5] = '{mask: 3'b110, gate: 10,  done_off: 79};
        vecs[6] = '{mask: 3'b101, gate: 3,   done_off: 72};

        rst = 1'b1; start = 1'b0; cont = 1'b0; gate = '0; mask = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            start_sweep(vecs[i].mask, vecs[i].gate, t);
            check("clear_entry_ctr_reset", int'(o_ctr_reset), 1);
            check("clear_entry_busy", int'(o_busy), 1);
            drain(400);
            check("done_offset", last_done - t, vecs[i].done_off);
            @(negedge clk);
            check("idle_after_done", all_outs(), 0);
        end

        // Zero mask with start held: nothing may move.
        mask = 3'b000; gate = 16'd7; start = 1'b1; any = 0;
        repeat (40) begin
            @(negedge clk);
            any |= all_outs();
        end
        start = 1'b0;
        check("zero_mask_idle", any, 0);

        // Start, mask and gate wiggled during GATE must be ignored.
        start_sweep(3'b001, 50, t);
        wait_until(t + 20);
        start = 1'b1; mask = 3'b111; gate = 16'd2;
        repeat (5) @(negedge clk);
        start = 1'b0;
        drain(400);
        check("midgate_done_offset", last_done - t, 91);

        // Continuous: three sweeps, continuous dropped during the third.
        cont = 1'b1;
        start_sweep(3'b101, 3, t);
        push_sweep(3'b101, 3, t + 72);
        push_sweep(3'b101, 3, t + 144);
        win_lo = t + 1; win_hi = t + 216; busy_low = 0;
        wait_until(t + 150);
        cont = 1'b0;
        drain(400);
        check("continuous_last_done", last_done - t, 216);
        check("continuous_busy_low_cycles", busy_low, 3);
        win_lo = -1; win_hi = -2;
        repeat (3) @(negedge clk);
        check("continuous_stopped", all_outs(), 0);

        // Reset in the middle of the second frame's SHIFT.
        start_sweep(3'b111, 4, t);
        wait_until(t + 55);
        check("second_shift_frame_active", int'(o_frame_active), 1);
        check("second_shift_select", int'(o_counter_select), 1);
        rst = 1'b1;
        #1;
        check("reset_midshift_outputs", all_outs(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", all_outs(), 0);
        start_sweep(vecs[0].mask, vecs[0].gate, t);
        check("post_reset_clear", int'(o_ctr_reset), 1);
        drain(400);
        check("post_reset_done_offset", last_done - t, vecs[0].done_off);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
